// File: rtl/axi4lite_arbiter.sv
// Two-master AXI4-Lite arbiter: IFU (read-only) and LSU (read/write) share one
// crossbar port, one transaction at a time, alternating reads when both contend.
module axi4lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_arvalid,
    input  logic [ADDR_WIDTH-1:0] ifu_araddr,
    output logic                  ifu_arready,
    output logic                  ifu_rvalid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic [1:0]            ifu_rresp,
    input  logic                  ifu_rready,

    input  logic                  lsu_arvalid,
    input  logic [ADDR_WIDTH-1:0] lsu_araddr,
    output logic                  lsu_arready,
    output logic                  lsu_rvalid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [1:0]            lsu_rresp,
    input  logic                  lsu_rready,
    input  logic                  lsu_awvalid,
    input  logic [ADDR_WIDTH-1:0] lsu_awaddr,
    output logic                  lsu_awready,
    input  logic                  lsu_wvalid,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [3:0]            lsu_wstrb,
    output logic                  lsu_wready,
    output logic                  lsu_bvalid,
    output logic [1:0]            lsu_bresp,
    input  logic                  lsu_bready,

    output logic                  out_arvalid,
    output logic [ADDR_WIDTH-1:0] out_araddr,
    input  logic                  out_arready,
    input  logic                  out_rvalid,
    input  logic [DATA_WIDTH-1:0] out_rdata,
    input  logic [1:0]            out_rresp,
    output logic                  out_rready,
    output logic                  out_awvalid,
    output logic [ADDR_WIDTH-1:0] out_awaddr,
    input  logic                  out_awready,
    output logic                  out_wvalid,
    output logic [DATA_WIDTH-1:0] out_wdata,
    output logic [3:0]            out_wstrb,
    input  logic                  out_wready,
    input  logic                  out_bvalid,
    input  logic [1:0]            out_bresp,
    output logic                  out_bready
);

    // state  | meaning
    // IDLE   | no grant; arbitrate sampled requests
    // IFU_RD | IFU read granted, AR/R forwarded
    // LSU_RD | LSU read granted, AR/R forwarded
    // LSU_WR | LSU write granted, AW/W/B forwarded
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   last_rd_q, last_rd_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q,  w_done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b1;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_rd_d   = last_rd_q;
        ar_done_d   = ar_done_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;

        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = '0;

        out_arvalid = 1'b0;
        out_araddr  = '0;
        out_rready  = 1'b0;
        out_awvalid = 1'b0;
        out_awaddr  = '0;
        out_wvalid  = 1'b0;
        out_wdata   = '0;
        out_wstrb   = '0;
        out_bready  = 1'b0;

        case (state_q)
            IDLE: begin
                // Writes win outright; contending reads go to whoever did not read last.
                if (lsu_awvalid) begin
                    state_d = LSU_WR;
                end else if (ifu_arvalid && lsu_arvalid) begin
                    state_d = last_rd_q ? IFU_RD : LSU_RD;
                end else if (ifu_arvalid) begin
                    state_d = IFU_RD;
                end else if (lsu_arvalid) begin
                    state_d = LSU_RD;
                end
            end

            IFU_RD: begin
                out_arvalid = ifu_arvalid & ~ar_done_q;
                out_araddr  = ifu_araddr;
                ifu_arready = out_arready & ~ar_done_q;
                ifu_rvalid  = out_rvalid;
                ifu_rdata   = out_rdata;
                ifu_rresp   = out_rresp;
                out_rready  = ifu_rready;
                if (ifu_arvalid && !ar_done_q && out_arready) begin
                    ar_done_d = 1'b1;
                end
                if (out_rvalid && ifu_rready) begin
                    state_d   = IDLE;
                    last_rd_d = 1'b0;
                    ar_done_d = 1'b0;
                end
            end

            LSU_RD: begin
                out_arvalid = lsu_arvalid & ~ar_done_q;
                out_araddr  = lsu_araddr;
                lsu_arready = out_arready & ~ar_done_q;
                lsu_rvalid  = out_rvalid;
                lsu_rdata   = out_rdata;
                lsu_rresp   = out_rresp;
                out_rready  = lsu_rready;
                if (lsu_arvalid && !ar_done_q && out_arready) begin
                    ar_done_d = 1'b1;
                end
                if (out_rvalid && lsu_rready) begin
                    state_d   = IDLE;
                    last_rd_d = 1'b1;
                    ar_done_d = 1'b0;
                end
            end

            LSU_WR: begin
                // AW and W complete independently, so each is masked after its own handshake.
                out_awvalid = lsu_awvalid & ~aw_done_q;
                out_awaddr  = lsu_awaddr;
                lsu_awready = out_awready & ~aw_done_q;
                out_wvalid  = lsu_wvalid & ~w_done_q;
                out_wdata   = lsu_wdata;
                out_wstrb   = lsu_wstrb;
                lsu_wready  = out_wready & ~w_done_q;
                lsu_bvalid  = out_bvalid;
                lsu_bresp   = out_bresp;
                out_bready  = lsu_bready;
                if (lsu_awvalid && !aw_done_q && out_awready) begin
                    aw_done_d = 1'b1;
                end
                if (lsu_wvalid && !w_done_q && out_wready) begin
                    w_done_d = 1'b1;
                end
                if (out_bvalid && lsu_bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Self-checking bench for axi4lite_arbiter: table of read transactions plus
// scripted write, contention and mid-write reset sequences.
module tb_axi4lite_arbiter;

    logic        clk, rst;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_bvalid, lsu_bready;
    logic [1:0]  lsu_bresp;
    logic        out_arvalid, out_arready, out_rvalid, out_rready;
    logic [31:0] out_araddr, out_rdata;
    logic [1:0]  out_rresp;
    logic        out_awvalid, out_awready, out_wvalid, out_wready;
    logic [31:0] out_awaddr, out_wdata;
    logic [3:0]  out_wstrb;
    logic        out_bvalid, out_bready;
    logic [1:0]  out_bresp;

    axi4lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
        .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .out_arvalid(out_arvalid), .out_araddr(out_araddr), .out_arready(out_arready),
        .out_rvalid(out_rvalid), .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rready(out_rready),
        .out_awvalid(out_awvalid), .out_awaddr(out_awaddr), .out_awready(out_awready),
        .out_wvalid(out_wvalid), .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wready(out_wready),
        .out_bvalid(out_bvalid), .out_bresp(out_bresp), .out_bready(out_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ifu_req;
        logic        lsu_req;
        logic        hold;
        int          dly;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        exp_lsu;
    } rd_vec_t;

    // who: 0 = IFU read, 1 = LSU read, 2 = LSU write
    typedef struct {
        logic [1:0]  who;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    rd_vec_t rv[8];
    exp_t    sbq[$];
    int      n_vec = 0;
    int      n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ifu_arvalid = 0; ifu_araddr = 0; ifu_rready = 0;
        lsu_arvalid = 0; lsu_araddr = 0; lsu_rready = 0;
        lsu_awvalid = 0; lsu_awaddr = 0; lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_bready = 0;
        out_arready = 0; out_rvalid = 0; out_rdata = 0; out_rresp = 0;
        out_awready = 0; out_wready = 0; out_bvalid = 0; out_bresp = 0;
    endtask

    task automatic do_read(input rd_vec_t v);
        exp_t e;
        tick();
        ifu_arvalid = v.ifu_req;
        lsu_arvalid = v.lsu_req;
        ifu_araddr  = v.exp_lsu ? ~v.addr : v.addr;
        lsu_araddr  = v.exp_lsu ? v.addr : ~v.addr;
        out_arready = 1; ifu_rready = 1; lsu_rready = 1;
        sbq.push_back('{v.exp_lsu ? 2'd1 : 2'd0, v.data, v.resp});
        settle();
        chk("rd_not_early", 32'({ifu_arready, lsu_arready, out_arvalid}), 0);
        tick(); settle();
        chk("rd_arvalid", 32'(out_arvalid), 1);
        chk("rd_araddr", out_araddr, v.addr);
        chk("rd_arready", 32'({ifu_arready, lsu_arready}), v.exp_lsu ? 1 : 2);
        tick();
        if (!v.hold) begin
            ifu_arvalid = 0; lsu_arvalid = 0;
        end
        settle();
        for (int i = 0; i < v.dly; i++) begin
            chk("rd_ar_masked", 32'({out_arvalid, ifu_arready, lsu_arready}), 0);
            chk("rd_no_early_r", 32'({ifu_rvalid, lsu_rvalid}), 0);
            tick(); settle();
        end
        out_rvalid = 1; out_rdata = v.data; out_rresp = v.resp;
        settle();
        chk("rd_ar_masked_r", 32'(out_arvalid), 0);
        chk("rd_r_route", 32'({ifu_rvalid, lsu_rvalid}), v.exp_lsu ? 1 : 2);
        chk("rd_rready", 32'(out_rready), 1);
        if (sbq.size() == 0) begin
            chk("rd_sb_empty", 1, 0);
        end else begin
            e = sbq.pop_front();
            chk("rd_rdata", (e.who == 2'd1) ? lsu_rdata : ifu_rdata, e.data);
            chk("rd_rresp", 32'((e.who == 2'd1) ? lsu_rresp : ifu_rresp), 32'(e.resp));
        end
        tick();
        clear_inputs();
        settle();
        chk("rd_back_idle", 32'({out_arvalid, ifu_rvalid, lsu_rvalid, out_rready}), 0);
    endtask

    // a1/w1: which of AW/W the slave accepts in the first forwarded cycle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] resp, input logic a1, input logic w1, input logic ifu_too);
        exp_t e;
        tick();
        lsu_awvalid = 1; lsu_awaddr = addr; lsu_wvalid = 1; lsu_wdata = data; lsu_wstrb = strb;
        ifu_arvalid = ifu_too; ifu_araddr = 32'h8000_0100; lsu_bready = 1; out_arready = 1;
        sbq.push_back('{2'd2, 32'd0, resp});
        settle();
        chk("wr_not_early", 32'({lsu_awready, lsu_wready, out_awvalid, out_wvalid, ifu_arready}), 0);
        tick();
        out_awready = a1; out_wready = w1;
        settle();
        chk("wr_fwd_valid", 32'({out_awvalid, out_wvalid, out_arvalid, ifu_arready}), 12);
        chk("wr_awaddr", out_awaddr, addr);
        chk("wr_wdata", out_wdata, data);
        chk("wr_wstrb", 32'(out_wstrb), 32'(strb));
        chk("wr_ready", 32'({lsu_awready, lsu_wready}), 32'({a1, w1}));
        tick();
        if (!(a1 && w1)) begin
            out_awready = 1; out_wready = 1;
            settle();
            chk("wr_single_mask", 32'({out_awvalid, out_wvalid, lsu_awready, lsu_wready}),
                32'({~a1, ~w1, ~a1, ~w1}));
            tick();
        end
        out_bvalid = 1; out_bresp = resp;
        settle();
        chk("wr_both_masked", 32'({out_awvalid, out_wvalid, lsu_awready, lsu_wready, ifu_arready}), 0);
        chk("wr_bvalid", 32'({lsu_bvalid, out_bready}), 3);
        if (sbq.size() == 0) begin
            chk("wr_sb_empty", 1, 0);
        end else begin
            e = sbq.pop_front();
            chk("wr_bresp", 32'(lsu_bresp), 32'(e.resp));
        end
        tick();
        clear_inputs();
        settle();
        chk("wr_back_idle", 32'({lsu_bvalid, out_bready, out_awvalid, out_wvalid}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           ifu lsu hold dly addr          data          resp   exp_lsu
        rv[0] = '{1'b1, 1'b0, 1'b0, 1, 32'h8000_0000, 32'h1234_5678, 2'b00, 1'b0};
        rv[1] = '{1'b1, 1'b1, 1'b0, 0, 32'h8000_0040, 32'hcafe_0001, 2'b00, 1'b1};
        rv[2] = '{1'b1, 1'b1, 1'b0, 2, 32'h8000_0044, 32'hcafe_0002, 2'b00, 1'b0};
        rv[3] = '{1'b1, 1'b1, 1'b0, 1, 32'h8000_0048, 32'hcafe_0003, 2'b01, 1'b1};
        rv[4] = '{1'b0, 1'b1, 1'b0, 2, 32'ha000_03f8, 32'h0bad_f00d, 2'b10, 1'b1};
        rv[5] = '{1'b1, 1'b0, 1'b1, 5, 32'h8000_0080, 32'h5a5a_a5a5, 2'b11, 1'b0};
        rv[6] = '{1'b1, 1'b0, 1'b0, 0, 32'h8000_0100, 32'h0000_0100, 2'b00, 1'b0};
        rv[7] = '{1'b1, 1'b1, 1'b0, 0, 32'h8000_0200, 32'h7777_8888, 2'b00, 1'b0};

        rst = 0;
        clear_inputs();
        ifu_arvalid = 1; lsu_awvalid = 1; lsu_wvalid = 1; out_arready = 1; out_awready = 1;
        out_wready = 1; out_rvalid = 1; out_bvalid = 1; out_rdata = 32'hdead_beef;
        ifu_rready = 1; lsu_bready = 1; ifu_araddr = 32'h1111_2222;
        #2;
        chk("reset_ctrl", 32'({out_arvalid, out_awvalid, out_wvalid, out_rready, out_bready, ifu_arready,
                               lsu_arready, lsu_awready, lsu_wready, ifu_rvalid, lsu_rvalid, lsu_bvalid}), 0);
        chk("reset_araddr", out_araddr, 0);
        chk("reset_rdata", ifu_rdata, 0);
        repeat (2) @(posedge clk);
        clear_inputs();
        #1 rst = 1;

        for (int i = 0; i < 6; i++) do_read(rv[i]);

        // Write and IFU read requested together; write must win, IFU waits.
        do_write(32'h9000_0010, 32'hfeed_0001, 4'hf, 2'b00, 1'b0, 1'b1, 1'b1);
        do_read(rv[6]);
        do_write(32'h9000_0020, 32'hfeed_0002, 4'h3, 2'b10, 1'b1, 1'b1, 1'b0);
        do_write(32'h9000_0030, 32'hfeed_0003, 4'hc, 2'b11, 1'b1, 1'b0, 1'b0);

        // Abort a write after its AW handshake.
        tick();
        lsu_awvalid = 1; lsu_awaddr = 32'h9000_0040; lsu_wvalid = 1; lsu_wdata = 32'h1; lsu_wstrb = 4'hf;
        lsu_bready = 1;
        tick();
        out_awready = 1;
        tick();
        out_wready = 1; out_bvalid = 1;
        settle();
        chk("rst_pre_wready", 32'({lsu_awready, lsu_wready}), 1);
        rst = 0;
        settle();
        chk("rst_mid_write", 32'({out_awvalid, out_wvalid, lsu_awready, lsu_wready, lsu_bvalid, out_bready}), 0);
        tick();
        clear_inputs();
        settle();
        rst = 1;

        // last read before reset was IFU; reset must restore IFU priority.
        do_read(rv[7]);
        do_write(32'h9000_0050, 32'hfeed_0005, 4'h1, 2'b00, 1'b0, 1'b1, 1'b0);

        chk("sb_drained", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
